// File: rtl/jericalla_pkg.sv
// jericalla_pkg
// Shared definitions for the Jericalla instruction sequencer:
//   - sequencer state enum
//   - control-field encodings of a program word
//   - bit offsets of the 17-bit datapath instruction
//   - helper returning the program-word width for a given PC/instruction width
package jericalla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Program word is {ctrl[1:0], target[PC_W-1:0], instr[INSTR_W-1:0]}
  localparam logic [1:0] CTRL_SEQ  = 2'b00;
  localparam logic [1:0] CTRL_BZ   = 2'b01;
  localparam logic [1:0] CTRL_JMP  = 2'b10;
  localparam logic [1:0] CTRL_HALT = 2'b11;

  // Datapath instruction {dirW, op, dirR1, dirR2, WEn}
  localparam int INSTR_WEN_BIT = 0;
  localparam int INSTR_R2_LSB  = 1;
  localparam int INSTR_R1_LSB  = 5;
  localparam int INSTR_OP_LSB  = 9;
  localparam int INSTR_DW_LSB  = 13;
  localparam int INSTR_FLD_W   = 4;

  function automatic int prog_word_w(input int pc_w, input int instr_w);
    return 2 + pc_w + instr_w;
  endfunction

endpackage

// File: rtl/jericalla_secuenciador_if.sv
// jericalla_secuenciador_if
// Groups the control, program-load and issue signals of the sequencer.
//   master : upstream controller / bench (drives start, stall, zf_in, load_*)
//   slave  : the sequencer (drives instruccion_out, valid_out, pc_out,
//            busy, done, issued_cnt)
interface jericalla_secuenciador_if
  import jericalla_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 17
) ();

  localparam int WORD_W = prog_word_w(PC_W, INSTR_W);

  logic               start;
  logic               stall;
  logic               zf_in;
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [WORD_W-1:0]  load_data;
  logic [INSTR_W-1:0] instruccion_out;
  logic               valid_out;
  logic [PC_W-1:0]    pc_out;
  logic               busy;
  logic               done;
  logic [15:0]        issued_cnt;

  modport master (
    output start, stall, zf_in, load_en, load_addr, load_data,
    input  instruccion_out, valid_out, pc_out, busy, done, issued_cnt
  );

  modport slave (
    input  start, stall, zf_in, load_en, load_addr, load_data,
    output instruccion_out, valid_out, pc_out, busy, done, issued_cnt
  );

endinterface

// File: rtl/jericalla_prog_mem.sv
// jericalla_prog_mem
// Program memory: 2^PC_W words, synchronous write, combinational read,
// no reset (contents survive rst_n).
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
module jericalla_prog_mem #(
  parameter int PC_W   = 4,
  parameter int WORD_W = 23
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PC_W-1:0]   i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [PC_W-1:0]   i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << PC_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle fetch decode needs the word without a read register.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jericalla_secuenciador.sv
// jericalla_secuenciador
// Instruction sequencer in front of the Jericalla datapath. Fetches one
// program word per unstalled RUN cycle, issues SEQ words to the datapath,
// consumes BZ/JMP/HALT internally.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of jericalla_secuenciador_if
//            (start, stall, zf_in, load_* in; instruccion_out, valid_out,
//             pc_out, busy, done, issued_cnt out)
module jericalla_secuenciador
  import jericalla_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  jericalla_secuenciador_if.slave  bus
);

  localparam int WORD_W = prog_word_w(PC_W, INSTR_W);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_next;
  logic [PC_W-1:0]    r_pc, w_pc_next;
  logic               r_zf, w_zf_next;
  logic [15:0]        r_cnt, w_cnt_next;
  logic [INSTR_W-1:0] r_instr, w_instr_next;
  logic               r_valid, w_valid_next;

  logic [WORD_W-1:0]  w_word;
  logic [1:0]         w_ctrl;
  logic [PC_W-1:0]    w_target;
  logic [INSTR_W-1:0] w_instr;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_mem_we;

  // Loads are only accepted while not executing.
  assign w_mem_we = bus.load_en && (r_state != ST_RUN);

  jericalla_prog_mem #(
    .PC_W   (PC_W),
    .WORD_W (WORD_W)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );

  assign w_ctrl   = w_word[WORD_W-1 -: 2];
  assign w_target = w_word[INSTR_W +: PC_W];
  assign w_instr  = w_word[INSTR_W-1:0];
  assign w_pc_inc = r_pc + PC_ONE;   // natural wrap at 2^PC_W

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_zf    <= 1'b0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_zf    <= w_zf_next;
      r_cnt   <= w_cnt_next;
      r_instr <= w_instr_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    w_instr_next = '0;      // bubble unless a SEQ word issues
    w_valid_next = 1'b0;
    // The flag belongs to whatever is on the output this cycle; capture it
    // at the end of every issue cycle, including one that a stall follows.
    w_zf_next    = r_valid ? bus.zf_in : r_zf;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
          w_pc_next    = '0;
          w_zf_next    = 1'b0;
          w_cnt_next   = '0;
        end
      end

      ST_RUN: begin
        if (!bus.stall) begin
          unique case (w_ctrl)
            CTRL_SEQ: begin
              w_instr_next = w_instr;
              w_valid_next = 1'b1;
              w_pc_next    = w_pc_inc;
              w_cnt_next   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            end
            CTRL_BZ: begin
              w_pc_next = r_zf ? w_target : w_pc_inc;
            end
            CTRL_JMP: begin
              w_pc_next = w_target;
            end
            CTRL_HALT: begin
              w_state_next = ST_DONE;
            end
            default: begin
              w_state_next = ST_DONE;
            end
          endcase
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.instruccion_out = r_instr;
  assign bus.valid_out       = r_valid;
  assign bus.pc_out          = r_pc;
  assign bus.busy            = (r_state == ST_RUN);
  assign bus.done            = (r_state == ST_DONE);
  assign bus.issued_cnt      = r_cnt;

endmodule

// File: tb/tb_jericalla_secuenciador.sv
module tb_jericalla_secuenciador;
  import jericalla_pkg::*;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 17;
  localparam int WORD_W  = 23;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jericalla_secuenciador_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  jericalla_secuenciador #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [INSTR_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every issued instruction must match the queue head,
  // every bubble must be all-zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got %h expected none", bus.instruccion_out);
        end else begin
          logic [INSTR_W-1:0] e;
          e = exp_q.pop_front();
          check("issue", 32'(bus.instruccion_out), 32'(e));
          $display("issue instr=%h expected=%h pc=%0d", bus.instruccion_out, e, bus.pc_out);
        end
      end else begin
        check("bubble_zero", 32'(bus.instruccion_out), 32'h0);
      end
    end
  end

  function automatic logic [WORD_W-1:0] mk(input logic [1:0] c, input logic [PC_W-1:0] t,
                                             input logic [INSTR_W-1:0] i);
    return {c, t, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PC_W-1:0] a, input logic [WORD_W-1:0] w);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = w;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      if (bus.done) break;
      tick();
    end
    check(name, 32'(bus.done), 32'h1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_instr"}, 32'(bus.instruccion_out), 32'h0);
    check({name, "_valid"}, 32'(bus.valid_out), 32'h0);
    check({name, "_pc"},    32'(bus.pc_out), 32'h0);
    check({name, "_busy"},  32'(bus.busy), 32'h0);
    check({name, "_done"},  32'(bus.done), 32'h0);
    check({name, "_cnt"},   32'(bus.issued_cnt), 32'h0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.zf_in     = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;

    // ---- reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset_outputs("idle");
    end

    // ---- straight-line program
    for (int a = 0; a < 16; a++) load(4'(a), mk(CTRL_HALT, 4'h0, 17'h0));
    load(4'd0, mk(CTRL_SEQ, 4'h0, 17'h1A2B4));
    load(4'd1, mk(CTRL_SEQ, 4'h0, 17'h0C3E1));
    load(4'd2, mk(CTRL_HALT, 4'h0, 17'h0));
    exp_q.push_back(17'h1A2B4);
    exp_q.push_back(17'h0C3E1);
    do_start();
    check("start_busy", 32'(bus.busy), 32'h1);
    wait_done("line_done");
    check("line_cnt",   32'(bus.issued_cnt), 32'd2);
    check("line_busy",  32'(bus.busy), 32'h0);
    check("line_pc",    32'(bus.pc_out), 32'd2);
    check("line_empty", 32'(exp_q.size()), 32'd0);

    // ---- branch taken / not taken (BZ at 2, target 5)
    load(4'd0, mk(CTRL_SEQ,  4'h0, 17'h00011));
    load(4'd1, mk(CTRL_SEQ,  4'h0, 17'h00022));
    load(4'd2, mk(CTRL_BZ,   4'h5, 17'h0));
    load(4'd3, mk(CTRL_SEQ,  4'h0, 17'h00033));
    load(4'd4, mk(CTRL_HALT, 4'h0, 17'h0));
    load(4'd5, mk(CTRL_SEQ,  4'h0, 17'h00055));
    load(4'd6, mk(CTRL_HALT, 4'h0, 17'h0));

    bus.zf_in = 1'b1;
    exp_q.push_back(17'h00011);
    exp_q.push_back(17'h00022);
    exp_q.push_back(17'h00055);
    do_start();
    wait_done("bz_t_done");
    check("bz_t_cnt",   32'(bus.issued_cnt), 32'd3);
    check("bz_t_pc",    32'(bus.pc_out), 32'd6);
    check("bz_t_empty", 32'(exp_q.size()), 32'd0);

    bus.zf_in = 1'b0;
    exp_q.push_back(17'h00011);
    exp_q.push_back(17'h00022);
    exp_q.push_back(17'h00033);
    do_start();
    wait_done("bz_n_done");
    check("bz_n_cnt",   32'(bus.issued_cnt), 32'd3);
    check("bz_n_pc",    32'(bus.pc_out), 32'd4);
    check("bz_n_empty", 32'(exp_q.size()), 32'd0);

    // ---- stall for 3 cycles after the first issue
    load(4'd0, mk(CTRL_SEQ,  4'h0, 17'h0ABCD));
    load(4'd1, mk(CTRL_SEQ,  4'h0, 17'h1F00F));
    load(4'd2, mk(CTRL_HALT, 4'h0, 17'h0));
    exp_q.push_back(17'h0ABCD);
    exp_q.push_back(17'h1F00F);
    do_start();
    tick();
    check("stall_first_valid", 32'(bus.valid_out), 32'h1);
    check("stall_first_pc",    32'(bus.pc_out), 32'd1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(bus.valid_out), 32'h0);
      check("stall_instr", 32'(bus.instruccion_out), 32'h0);
      check("stall_pc",    32'(bus.pc_out), 32'd1);
      check("stall_busy",  32'(bus.busy), 32'h1);
    end
    bus.stall = 1'b0;
    tick();
    check("resume_valid", 32'(bus.valid_out), 32'h1);
    wait_done("stall_done");
    check("stall_cnt",   32'(bus.issued_cnt), 32'd2);
    check("stall_empty", 32'(exp_q.size()), 32'd0);

    // ---- wrap/loop: SEQ 0..14, JMP 0 at 15; load during RUN ignored
    for (int a = 0; a < 15; a++) load(4'(a), mk(CTRL_SEQ, 4'h0, 17'(32'h100 + a)));
    load(4'd15, mk(CTRL_JMP, 4'h0, 17'h0));
    for (int n = 0; n < 40; n++) exp_q.push_back(17'(32'h100 + (n % 15)));
    do_start();
    for (int i = 0; i < 200; i++) begin
      if (bus.issued_cnt == 16'd40) break;
      if (i == 10) load(4'd3, mk(CTRL_HALT, 4'h0, 17'h0));
      else tick();
    end
    check("loop_cnt",  32'(bus.issued_cnt), 32'd40);
    check("loop_pc",   32'(bus.pc_out), 32'd10);
    check("loop_busy", 32'(bus.busy), 32'h1);

    // ---- reset mid-run
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("loop_empty", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load(4'd5, mk(CTRL_HALT, 4'h0, 17'h0));
    for (int n = 0; n < 5; n++) exp_q.push_back(17'(32'h100 + n));
    do_start();
    wait_done("rerun_done");
    check("rerun_cnt",   32'(bus.issued_cnt), 32'd5);
    check("rerun_pc",    32'(bus.pc_out), 32'd5);
    check("rerun_empty", 32'(exp_q.size()), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
